adder_8: RTL and testbench



---
 rtl/adder_8_pkg.sv | 6 +
 rtl/full_adder.sv | 13 +
 rtl/adder_8.sv | 61 ++++++
 tb/tb_adder_8.sv | 133 +++++++++++++
 4 files changed

// File: rtl/adder_8_pkg.sv
// Shared constants for the 8-bit add/subtract datapath.
package adder_8_pkg;
  localparam int unsigned WIDTH = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the ripple-chain stage of adder_8.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end
endmodule

// File: rtl/adder_8.sv
// 8-bit add/subtract: combinational result/carry plus a registered copy with status flags.
module adder_8
  import adder_8_pkg::*;
#(
  parameter int unsigned WIDTH = adder_8_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic [WIDTH-1:0] y_q,
  output logic             carry_q,
  output logic             overflow_q,
  output logic             zero_q,
  output logic             negative_q
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   chain;
  logic             overflow;
  logic             zero;

  // carry_in doubles as the op select: inverting b and injecting 1 gives a - b.
  assign b_eff    = b ^ {WIDTH{carry_in == OP_SUB}};
  assign chain[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (chain[i]),
      .s    (y[i]),
      .cout (chain[i+1])
    );
  end

  assign carry = chain[WIDTH];

  always_comb begin
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    zero     = (y == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      y_q        <= y;
      carry_q    <= carry;
      overflow_q <= overflow;
      zero_q     <= zero;
      negative_q <= y[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_adder_8.sv
// Directed bench for adder_8: combinational checks immediately, registered checks via scoreboard.
module tb_adder_8;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       carry_in;
  logic [7:0] y, y_q;
  logic       carry, carry_q, overflow_q, zero_q, negative_q;

  typedef struct packed {
    logic [7:0] y;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  adder_8 dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .y          (y),
    .carry      (carry),
    .y_q        (y_q),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
    .zero_q     (zero_q),
    .negative_q (negative_q)
  );

  always #5 clk = ~clk;

  // Reference built from integer arithmetic rather than bit-level logic.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic sub);
    exp_t e;
    int   ua, ub, sa, sb, ures, sres;
    ua = int'(ma);
    ub = int'(mb);
    sa = ma[7] ? ua - 256 : ua;
    sb = mb[7] ? ub - 256 : ub;
    if (sub) begin
      ures    = ua - ub;
      sres    = sa - sb;
      e.carry = (ua >= ub);
    end else begin
      ures    = ua + ub;
      sres    = sa + sb;
      e.carry = (ures > 255);
    end
    e.y        = 8'(ures);
    e.overflow = (sres > 127) || (sres < -128);
    e.zero     = (e.y == 8'h00);
    e.negative = e.y[7];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Drive one vector mid-cycle, check the combinational path, queue the registered expectation.
  task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb, input logic c);
    exp_t e;
    @(negedge clk);
    rst      = r;
    a        = va;
    b        = vb;
    carry_in = c;
    #1;
    e = model(va, vb, c);
    chk("comb_y", y, e.y);
    chk("comb_carry", {7'b0, carry}, {7'b0, e.carry});
    exp_q.push_back(r ? exp_t'(0) : e);
  endtask

  task automatic capture();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("y_q", y_q, e.y);
      chk("carry_q", {7'b0, carry_q}, {7'b0, e.carry});
      chk("overflow_q", {7'b0, overflow_q}, {7'b0, e.overflow});
      chk("zero_q", {7'b0, zero_q}, {7'b0, e.zero});
      chk("negative_q", {7'b0, negative_q}, {7'b0, e.negative});
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; carry_in = 1'b0;
    // Reset state: zero_q stays 0 even though y is 0.
    drive(1'b1, 8'h00, 8'h00, 1'b0); capture();
    // Subtract with reset still high: combinational path valid, registers held at 0.
    drive(1'b1, 8'd8, 8'd5, 1'b1); capture();
    drive(1'b0, 8'd5, 8'd5, 1'b0); capture();
    drive(1'b0, 8'd8, 8'd5, 1'b0); capture();
    drive(1'b0, 8'd8, 8'd5, 1'b1); capture();
    drive(1'b0, 8'd5, 8'd8, 1'b1); capture();
    drive(1'b0, 8'hFF, 8'h01, 1'b0); capture();
    drive(1'b0, 8'h7F, 8'h01, 1'b0); capture();
    drive(1'b0, 8'h80, 8'h01, 1'b1); capture();
    drive(1'b0, 8'h80, 8'h80, 1'b0); capture();
    drive(1'b0, 8'h33, 8'h33, 1'b1); capture();
    // Mid-stream reset after a nonzero load, then release captures the live inputs.
    drive(1'b0, 8'hC0, 8'h10, 1'b0); capture();
    drive(1'b1, 8'd3, 8'd4, 1'b0); capture();
    drive(1'b0, 8'd3, 8'd4, 1'b0); capture();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      capture();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
